seg7_scan_driver: RTL and testbench

//   Downstream consumer of the processor GPIO port (gpio_o/we_gpio). Latches the
//   32-bit GPIO word and drives a time-multiplexed bank of NUM_DIGITS common-anode
//   7-segment digits, one hex nibble per digit, with optional leading-zero blanking.

---
 rtl/seg7_scan_driver.sv | 133 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Latches a GPIO word and scans it onto a bank of common-anode 7-segment
// digits through one shared active-low segment bus plus one-hot-low digit
// enables. Each digit slot lasts SCAN_DIV cycles; the first GUARD cycles of
// every slot are dark so the previous digit's segments never ghost onto the
// next anode. Leading zero digits can be blanked (digit 0 always shows).
//
// Interface timing: gpio_we is a plain write strobe with no ready/stall; the
// word present on gpio_data at any rising edge where gpio_we=1 is captured,
// and the last such write wins. All display outputs are registered and derive
// from the scan position, the latched word and blank_i as they stand before
// each edge, so they trail those inputs by exactly one cycle.
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 1024,
  parameter int GUARD      = 2,
  parameter int BLANK_LZ   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    gpio_we,
  input  logic [4*NUM_DIGITS-1:0] gpio_data,
  input  logic                    blank_i,
  output logic [6:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);
  localparam logic [6:0]    SEG_ZERO = 7'b1000000;

  logic [4*NUM_DIGITS-1:0] value_q;
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;

  logic [NUM_DIGITS-1:0]   upper_zero;
  logic                    zero_run;
  logic [3:0]              cur_nib;
  logic                    cur_upper_zero;
  logic                    lz_blank;
  logic                    dark;
  logic [6:0]              seg_next;
  logic [NUM_DIGITS-1:0]   an_next;

  // Display word register: captured on every strobe, no back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else if (gpio_we) begin
      value_q <= gpio_data;
    end
  end

  // Slot prescaler and digit index; frame_tick marks the wrap to digit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= (cnt == CNT_LAST) && (idx == IDX_LAST);
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Select the active nibble, work out blanking and decode the segments.
  always_comb begin
    upper_zero     = '0;
    zero_run       = 1'b1;
    cur_nib        = 4'h0;
    cur_upper_zero = 1'b0;
    seg_next       = 7'b0110110;

    // upper_zero[i] is set when nibbles i..NUM_DIGITS-1 are all zero.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run      = zero_run & (value_q[4*i +: 4] == 4'h0);
      upper_zero[i] = zero_run;
    end

    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib        = value_q[4*i +: 4];
        cur_upper_zero = upper_zero[i];
      end
    end

    lz_blank = (BLANK_LZ != 0) && (idx != '0) && cur_upper_zero;
    dark     = blank_i || (cnt < GUARD_C) || lz_blank;
    an_next  = dark ? '1 : ~(NUM_DIGITS'(1) << idx);

    // Segments are decoded even while dark; only the anodes gate light.
    case (cur_nib)
      4'h0:    seg_next = 7'b1000000;
      4'h1:    seg_next = 7'b1111001;
      4'h2:    seg_next = 7'b0100100;
      4'h3:    seg_next = 7'b0110000;
      4'h4:    seg_next = 7'b0011001;
      4'h5:    seg_next = 7'b0010010;
      4'h6:    seg_next = 7'b0000010;
      4'h7:    seg_next = 7'b1111000;
      4'h8:    seg_next = 7'b0000000;
      4'h9:    seg_next = 7'b0011000;
      4'hA:    seg_next = 7'b0001000;
      4'hB:    seg_next = 7'b0000011;
      4'hC:    seg_next = 7'b1000110;
      4'hD:    seg_next = 7'b0100001;
      4'hE:    seg_next = 7'b0000110;
      4'hF:    seg_next = 7'b0001110;
      default: seg_next = 7'b0110110;
    endcase
  end

  // Registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n <= SEG_ZERO;
      an_n  <= '1;
    end else begin
      seg_n <= seg_next;
      an_n  <= an_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
// Two instances share all inputs: one without and one with leading-zero
// blanking. A reference model derives every expected output from the number
// of cycles since reset (slot = t / SCAN_DIV mod digits, position = t mod
// SCAN_DIV), the written word and blank_i.
module tb_seg7_scan_driver;

  localparam int N     = 8;
  localparam int SD    = 4;
  localparam int GD    = 1;
  localparam int FRAME = SD * N;

  // Clock / reset block
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        gpio_we;
  logic [31:0] gpio_data;
  logic        blank_i;
  logic [6:0]  seg_n0, seg_n1;
  logic [7:0]  an_n0, an_n1;
  logic        ft0, ft1;

  seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(SD), .GUARD(GD), .BLANK_LZ(0)) dut_nolz (
    .clk(clk), .rst_n(rst_n), .gpio_we(gpio_we), .gpio_data(gpio_data),
    .blank_i(blank_i), .seg_n(seg_n0), .an_n(an_n0), .frame_tick(ft0)
  );

  seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(SD), .GUARD(GD), .BLANK_LZ(1)) dut_lz (
    .clk(clk), .rst_n(rst_n), .gpio_we(gpio_we), .gpio_data(gpio_data),
    .blank_i(blank_i), .seg_n(seg_n1), .an_n(an_n1), .frame_tick(ft1)
  );

  int checks;
  int failures;

  // Reference model state
  int          t;
  logic [31:0] m_value;
  logic [6:0]  dec_tab [16];

  // Scoreboard of expected outputs for the edge just evaluated
  logic [6:0]  e_seg;
  logic [7:0]  e_an0, e_an1;
  logic        e_ft;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h t=%0d", tag, obs, exp, t);
    end
  endtask

  function automatic logic lz_model(input logic [31:0] v, input int slot, input int en);
    return (en != 0) && (slot != 0) && ((v >> (4 * slot)) == 32'd0);
  endfunction

  // Driver: one clock edge, model update, and comparison of both instances.
  task automatic tick();
    int         slot;
    int         pos;
    logic [3:0] nib;
    logic       dark_common;
    @(posedge clk);
    slot        = (t / SD) % N;
    pos         = t % SD;
    nib         = 4'((m_value >> (4 * slot)) & 32'hF);
    e_seg       = dec_tab[nib];
    dark_common = blank_i || (pos < GD);
    e_an0       = (dark_common || lz_model(m_value, slot, 0)) ? 8'hFF : ~(8'h01 << slot);
    e_an1       = (dark_common || lz_model(m_value, slot, 1)) ? 8'hFF : ~(8'h01 << slot);
    e_ft        = ((t % FRAME) == FRAME - 1);
    if (gpio_we) m_value = gpio_data;
    t++;
    #1;
    check("seg_nolz", seg_n0, e_seg);
    check("an_nolz",  an_n0,  e_an0);
    check("ft_nolz",  ft0,    e_ft);
    check("seg_lz",   seg_n1, e_seg);
    check("an_lz",    an_n1,  e_an1);
    check("ft_lz",    ft1,    e_ft);
  endtask

  // Advance until the outputs reflect (slot, pos) of the scan; bounded to a frame.
  task automatic run_to(input int slot, input int pos);
    for (int k = 0; k <= FRAME; k++) begin
      tick();
      if (((t - 1) % FRAME) == slot * SD + pos) break;
    end
  endtask

  task automatic write_word(input logic [31:0] d);
    gpio_we   = 1'b1;
    gpio_data = d;
    tick();
    gpio_we   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_seg0"}, seg_n0, 7'b1000000);
    check({tag, "_an0"},  an_n0,  8'hFF);
    check({tag, "_ft0"},  ft0,    1'b0);
    check({tag, "_seg1"}, seg_n1, 7'b1000000);
    check({tag, "_an1"},  an_n1,  8'hFF);
    check({tag, "_ft1"},  ft1,    1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lead;
    logic [31:0] d;
    dec_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    checks    = 0;
    failures  = 0;
    t         = 0;
    m_value   = 32'd0;
    rst_n     = 1'b0;
    gpio_we   = 1'b0;
    gpio_data = 32'd0;
    blank_i   = 1'b0;

    // Power-on reset
    #7;
    check_reset_outputs("por");
    #14;
    rst_n = 1'b1;

    // No leading-zero blanking vs blanking, mixed word
    write_word(32'h1234ABCD);
    run_to(0, 2);
    check("d0_an_nolz", an_n0, 8'hFE);
    check("d0_seg_D", seg_n0, 7'b0100001);
    run_to(7, 1);
    check("d7_an_nolz", an_n0, 8'h7F);
    check("d7_seg_1", seg_n0, 7'b1111001);
    run_to(3, 0);
    check("guard_an_nolz", an_n0, 8'hFF);
    check("guard_an_lz", an_n1, 8'hFF);

    // Leading-zero blanking
    write_word(32'h000000A0);
    run_to(1, 2);
    check("lz_d1_an", an_n1, 8'hFD);
    check("lz_d1_seg_A", seg_n1, 7'b0001000);
    run_to(0, 2);
    check("lz_d0_an", an_n1, 8'hFE);
    check("lz_d0_seg_0", seg_n1, 7'b1000000);
    run_to(4, 2);
    check("lz_d4_dark", an_n1, 8'hFF);
    check("nolz_d4_lit", an_n0, 8'hEF);
    write_word(32'h00000000);
    run_to(0, 2);
    check("zero_d0_an", an_n1, 8'hFE);
    check("zero_d0_seg", seg_n1, 7'b1000000);
    run_to(1, 2);
    check("zero_d1_dark", an_n1, 8'hFF);

    // Mid-slot write on the 2nd cycle of digit 3
    run_to(3, 0);
    write_word(32'h00007000);
    tick();
    check("midslot_seg_7", seg_n1, 7'b1111000);
    check("midslot_an", an_n1, 8'hF7);

    // Back-to-back writes: last wins
    gpio_we   = 1'b1;
    gpio_data = 32'h11111111;
    tick();
    gpio_data = 32'h22222222;
    tick();
    gpio_we   = 1'b0;
    run_to(5, 2);
    check("b2b_d5_seg_2", seg_n0, 7'b0100100);
    run_to(0, 2);
    check("b2b_d0_seg_2", seg_n1, 7'b0100100);

    // Forced blank while scanning continues
    blank_i = 1'b1;
    repeat (40) tick();
    blank_i = 1'b0;
    run_to(2, 2);
    check("unblank_d2_an", an_n0, 8'hFB);

    // Asynchronous reset during digit 5, write ignored while held
    write_word(32'h89ABCDEF);
    run_to(5, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    gpio_we   = 1'b1;
    gpio_data = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    gpio_we = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("rst_held");
    #3;
    rst_n   = 1'b1;
    t       = 0;
    m_value = 32'd0;
    run_to(0, 2);
    check("post_rst_d0_an", an_n1, 8'hFE);
    run_to(1, 2);
    check("post_rst_d1_dark", an_n1, 8'hFF);

    // Randomised writes and blanking against the model
    for (int i = 0; i < 400; i++) begin
      gpio_we = ($urandom_range(0, 7) == 0);
      lead    = $urandom_range(0, 8);
      d       = $urandom;
      gpio_data = (lead == 8) ? 32'd0 : (d >> (4 * lead));
      if ($urandom_range(0, 15) == 0) blank_i = ~blank_i;
      tick();
    end
    gpio_we = 1'b0;
    blank_i = 1'b0;
    repeat (FRAME) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
